// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame controller driving an external LSB-first shifter
module uart_tx_ctrl #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       shift_txd,
  output logic       load,
  output logic [7:0] din,
  output logic       en,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        txd_q, done_q, done_d;
  logic        line;
  logic        tick;

  assign tick = (baud_cnt_q == BAUD_LAST) && (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = tick ? 16'd0 : baud_cnt_q + 16'd1;
    bit_cnt_d  = bit_cnt_q;
    done_d     = 1'b0;
    line       = 1'b1;
    load       = 1'b0;
    en         = 1'b0;
    case (state_q)
      IDLE: begin
        baud_cnt_d = 16'd0;
        load       = tx_start && !rst;
        if (tx_start) state_d = START;
      end
      START: begin
        line = 1'b0;
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        // The shifter advances on the same edge that ends the current bit.
        line = shift_txd;
        en   = tick && !rst;
        if (tick) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      txd_q      <= line;
      done_q     <= done_d;
    end
  end

  assign din  = tx_data;
  assign txd  = txd_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
